fsm_serialtx: RTL and testbench
===============================

# fsm_serialtx

Serial byte transmitter that produces the frame format the team's serial-data receiver FSM consumes. Each frame is a start bit (0), 8 data bits LSB first, an optional even-parity bit, and a stop bit (1). The line idles at 1. The block sits between a byte-producing core and the serial line. A one-entry holding register lets consecutive frames go out with no idle gap, so the receiver's STOP -> DONE -> B0 path is exercised at full rate.

## Interface
- BIT_CYCLES, 1: clocks each serial bit is held (>= 1).
- PARITY_EN, 0: 1 inserts an even-parity bit between the data bits and the stop bit.
- clk  input  1  sole clock; everything updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_byte  input  8  byte to transmit; sampled when in_valid & in_ready.
- in_valid  input  1  producer has a byte.
- in_ready  output  1  holding register empty; equals !hold_full.
- out  output  1  serial line, registered; 1 when idle.
- busy  output  1  registered; 1 while a frame is on the line.
- done  output  1  registered one-cycle pulse during the final clock of each stop bit.

## Operation
- Storage:
  - shift register (8 bits) plus parity bit for the frame on the line;
  - holding register plus hold_full flag;
  - bit-cycle counter, width clog2(BIT_CYCLES), minimum 1;
  - bit index 0..7.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is only entered when PARITY_EN=1.
- Line value per state: IDLE 1, START 0, DATA shift[bit index], PARITY ^data, STOP 1.
- Accept (in_valid & in_ready at an edge):
  - if the engine is IDLE, or is in the final clock of STOP, the byte loads directly into the shift register and the state becomes START;
  - otherwise the byte loads into the holding register and hold_full is set.
- Bit timing: each state lasts BIT_CYCLES clocks. The counter resets on every state change. DATA lasts 8*BIT_CYCLES clocks, and the bit index advances every BIT_CYCLES clocks.
- Transitions:
  - START -> DATA;
  - DATA (bit 7 done) -> PARITY if PARITY_EN, else STOP;
  - PARITY -> STOP;
  - STOP end -> START if hold_full (holding register moves to the shift register and hold_full clears), else START if a direct accept occurs that edge, else IDLE.
- Priority at STOP end: when hold_full=1, in_ready=0, so no direct accept can collide with the holding register.
- Parity: even, equal to the XOR of the 8 data bits. It is computed at load time and not recomputed.
- busy = (state != IDLE). done = 1 exactly during the last clock of STOP, once per frame.
- Reset, asynchronous and valid mid-frame:
  - state returns to IDLE and any in-progress frame is abandoned;
  - hold_full clears, discarding any held byte;
  - counters clear;
  - out=1, busy=0, done=0, in_ready=1.
- The first frame after reset starts only on a fresh accept.

## Timing
- Latency from an accepting edge (engine idle) to the start bit on out: 1 clock. out shows 0 in the cycle immediately after the edge.
- Frame length: (10 + PARITY_EN) * BIT_CYCLES clocks.
- Back-to-back frames: the next start bit immediately follows the final stop clock. There is exactly one stop bit and no idle cycles.
- in_ready falls the cycle after a byte enters the holding register. It rises the cycle after the holding register transfers to the engine.
- Sustained throughput: one byte per frame time with in_valid held high.
- An in_valid deassertion between frames leaves the line at 1 with busy=0.

## Test plan
- Reset mid-frame, asserted during data bit 3:
  - required response: out=1, busy=0, done=0, in_ready=1 asynchronously;
  - a later accept of 0x3C produces a clean, complete frame.
- Single byte, BIT_CYCLES=1, PARITY_EN=0, accept 0xA5 from idle:
  - out over 10 clocks: 0,1,0,1,0,0,1,0,1,1;
  - busy=1 for those 10 clocks;
  - done=1 only on clock 10;
  - out=1 afterwards.
- Back-to-back 0x01 then 0x80, with the second byte offered during the first frame:
  - in_ready=0 until the transfer;
  - 20 contiguous clocks: 0,1,0,0,0,0,0,0,0,1 then 0,0,0,0,0,0,0,0,1,1;
  - two done pulses, 10 clocks apart.
- Parity, PARITY_EN=1, byte 0x07:
  - out: 0,1,1,1,0,0,0,0,0,1,1 (parity 1, then stop);
  - done on clock 11.
- Stretched bits, BIT_CYCLES=4, byte 0xFF:
  - start low for 4 clocks, then the line high for 36 clocks;
  - done high for exactly 1 clock, on clock 40;
  - busy=1 for 40 clocks.
- Loopback into the receiver FSM (BIT_CYCLES=1, PARITY_EN=0), streaming 0x00, 0xFF, 0x5A with in_valid held high:
  - the receiver asserts done three times with out_byte 0x00, 0xFF, 0x5A;
  - the receiver never enters its error state.

Source files
------------

// File: rtl/fsm_serialtx_if.sv
// fsm_serialtx_if: byte handshake between a producing core and the
// serial transmitter.
interface fsm_serialtx_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/fsm_serialtx.sv
// fsm_serialtx: start / 8 data LSB-first / optional even parity / stop
// serializer with a one-entry holding register for gap-free frames.
module fsm_serialtx #(
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 0
) (
    input  logic          clk,
    input  logic          reset,
    fsm_serialtx_if.slave in_if,
    output logic          out,
    output logic          busy,
    output logic          done
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shift, shift_d;
    logic          par, par_d;
    logic [7:0]    hold, hold_d;
    logic          hold_full, hold_full_d;
    logic          out_d, busy_d, done_d;
    logic          bit_end, accept, direct;

    assign in_if.in_ready = !hold_full;
    assign bit_end = (cnt == LAST);
    assign accept  = in_if.in_valid && !hold_full;
    // A byte skips the holding register when the line is free next clock
    assign direct  = (state == IDLE) || (state == STOP && bit_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            par       <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            out       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            shift     <= shift_d;
            par       <= par_d;
            hold      <= hold_d;
            hold_full <= hold_full_d;
            out       <= out_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = bit_end ? '0 : cnt + CW'(1);
        idx_d       = idx;
        shift_d     = shift;
        par_d       = par;
        hold_d      = hold;
        hold_full_d = hold_full;
        if (accept && !direct) begin
            hold_d      = in_if.in_byte;
            hold_full_d = 1'b1;
        end
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = START;
                    shift_d = in_if.in_byte;
                    par_d   = ^in_if.in_byte;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    idx_d = idx + 3'd1;
                    if (idx == 3'd7) begin
                        if (PARITY_EN != 0) state_d = PARITY;
                        else state_d = STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (hold_full) begin
                        state_d     = START;
                        shift_d     = hold;
                        par_d       = ^hold;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        state_d = START;
                        shift_d = in_if.in_byte;
                        par_d   = ^in_if.in_byte;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so they register cleanly
    always_comb begin
        out_d  = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == LAST);
        unique case (state_d)
            IDLE:    out_d = 1'b1;
            START:   out_d = 1'b0;
            DATA:    out_d = shift_d[idx_d];
            PARITY:  out_d = par_d;
            STOP:    out_d = 1'b1;
            default: out_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_fsm_serialtx.sv
// tb_fsm_serialtx: three transmitter configurations against a per-clock
// line model, directed frames, back-to-back, reset and receiver loopback.
module tb_fsm_serialtx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] byte_v [3];
    logic [2:0] valid_v;
    wire  [2:0] out_w, busy_w, done_w, ready_w;

    fsm_serialtx_if ifa ();
    fsm_serialtx_if ifp ();
    fsm_serialtx_if ifs ();

    assign ifa.in_byte  = byte_v[0];
    assign ifa.in_valid = valid_v[0];
    assign ifp.in_byte  = byte_v[1];
    assign ifp.in_valid = valid_v[1];
    assign ifs.in_byte  = byte_v[2];
    assign ifs.in_valid = valid_v[2];
    assign ready_w[0] = ifa.in_ready;
    assign ready_w[1] = ifp.in_ready;
    assign ready_w[2] = ifs.in_ready;

    fsm_serialtx #(.BIT_CYCLES(1), .PARITY_EN(0)) dut_a (
        .clk(clk), .reset(reset), .in_if(ifa),
        .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );
    fsm_serialtx #(.BIT_CYCLES(1), .PARITY_EN(1)) dut_p (
        .clk(clk), .reset(reset), .in_if(ifp),
        .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );
    fsm_serialtx #(.BIT_CYCLES(4), .PARITY_EN(0)) dut_s (
        .clk(clk), .reset(reset), .in_if(ifs),
        .out(out_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each frame is expanded into one queue entry per line clock
    bit         mq [3][$];
    bit         m_full [3];
    logic [7:0] m_hold [3];
    int         bcs [3] = '{1, 1, 4};
    int         pes [3] = '{0, 1, 0};

    task automatic push_sym(input int d, input bit v);
        for (int r = 0; r < bcs[d]; r++) mq[d].push_back(v);
    endtask

    task automatic push_frame(input int d, input logic [7:0] b);
        push_sym(d, 1'b0);
        for (int i = 0; i < 8; i++) push_sym(d, b[i]);
        if (pes[d] != 0) push_sym(d, ^b);
        push_sym(d, 1'b1);
    endtask

    task automatic mdl_edge(input int d);
        bit acc;
        acc = valid_v[d] && !m_full[d];
        if (mq[d].size() > 0) void'(mq[d].pop_front());
        if (mq[d].size() == 0) begin
            if (m_full[d]) begin
                push_frame(d, m_hold[d]);
                m_full[d] = 1'b0;
            end else if (acc) begin
                push_frame(d, byte_v[d]);
            end
        end else if (acc) begin
            m_hold[d] = byte_v[d];
            m_full[d] = 1'b1;
        end
    endtask

    task automatic mdl_reset();
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            m_full[d] = 1'b0;
        end
    endtask

    task automatic mdl_chk();
        bit e_out;
        for (int d = 0; d < 3; d++) begin
            e_out = (mq[d].size() > 0) ? mq[d][0] : 1'b1;
            chk($sformatf("d%0d out", d), out_w[d], e_out);
            chk($sformatf("d%0d busy", d), busy_w[d], mq[d].size() > 0);
            chk($sformatf("d%0d done", d), done_w[d], mq[d].size() == 1);
            chk($sformatf("d%0d ready", d), ready_w[d], !m_full[d]);
        end
    endtask

    // Behavioural receiver: start, 8 bits LSB first, stop must be 1
    bit         rx_en = 1'b0;
    int         rx_st = 0;
    int         rx_err = 0;
    logic [7:0] rx_sh;
    logic [7:0] rx_got [$];

    task automatic rx_step(input logic v);
        if (rx_st == 0) begin
            if (v == 1'b0) rx_st = 1;
        end else if (rx_st <= 8) begin
            rx_sh[rx_st-1] = v;
            rx_st++;
        end else if (rx_st == 9) begin
            if (v == 1'b1) begin
                rx_got.push_back(rx_sh);
                rx_st = 0;
            end else begin
                rx_err++;
                rx_st = 10;
            end
        end else if (v == 1'b1) begin
            rx_st = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 3; d++) mdl_edge(d);
        #1;
        mdl_chk();
        if (rx_en) rx_step(out_w[0]);
    endtask

    typedef struct {
        int          dut;
        logic [7:0]  b;
        int          len;
        logic [63:0] line;
    } vec_t;

    vec_t       vt [5];
    logic [19:0] ln, dn, rd;
    logic [7:0] src [$];
    logic [7:0] rx_exp [3];
    bit         acc0;
    int         d;

    initial begin
        vt[0] = '{dut: 0, b: 8'h3C, len: 10, line: 64'b0001111001};
        vt[1] = '{dut: 0, b: 8'hA5, len: 10, line: 64'b0101001011};
        vt[2] = '{dut: 1, b: 8'h07, len: 11, line: 64'b01110000011};
        vt[3] = '{dut: 1, b: 8'h3C, len: 11, line: 64'b00011110001};
        vt[4] = '{dut: 2, b: 8'hFF, len: 40, line: 64'h0F_FFFF_FFFF};

        valid_v = '0;
        for (int i = 0; i < 3; i++) byte_v[i] = 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst d%0d out", i), out_w[i], 1);
            chk($sformatf("rst d%0d busy", i), busy_w[i], 0);
            chk($sformatf("rst d%0d done", i), done_w[i], 0);
            chk($sformatf("rst d%0d ready", i), ready_w[i], 1);
        end
        reset = 1'b0;
        mdl_reset();
        repeat (3) tick();

        // Reset during data bit 3 with a byte waiting in the holding register
        byte_v[0] = 8'h00;
        valid_v[0] = 1'b1;
        tick();
        byte_v[0] = 8'h5A;
        tick();
        valid_v[0] = 1'b0;
        repeat (3) tick();
        chk("pre-reset ready", ready_w[0], 0);
        chk("pre-reset out", out_w[0], 0);
        #2 reset = 1'b1;
        #1;
        chk("async rst out", out_w[0], 1);
        chk("async rst busy", busy_w[0], 0);
        chk("async rst done", done_w[0], 0);
        chk("async rst ready", ready_w[0], 1);
        mdl_reset();
        #2 reset = 1'b0;
        repeat (15) tick();

        for (int i = 0; i < 5; i++) begin
            d = vt[i].dut;
            byte_v[d] = vt[i].b;
            valid_v[d] = 1'b1;
            for (int k = 1; k <= vt[i].len; k++) begin
                tick();
                valid_v[d] = 1'b0;
                chk($sformatf("vec%0d line clk%0d", i, k), out_w[d],
                    vt[i].line[vt[i].len-k]);
                chk($sformatf("vec%0d done clk%0d", i, k), done_w[d],
                    k == vt[i].len);
                chk($sformatf("vec%0d busy clk%0d", i, k), busy_w[d], 1);
            end
            tick();
            chk($sformatf("vec%0d idle out", i), out_w[d], 1);
            chk($sformatf("vec%0d idle busy", i), busy_w[d], 0);
        end

        // Back-to-back 0x01 then 0x80, second byte offered mid-frame
        for (int k = 0; k < 20; k++) begin
            byte_v[0] = (k == 0) ? 8'h01 : 8'h80;
            valid_v[0] = (k < 2);
            tick();
            ln[19-k] = out_w[0];
            dn[19-k] = done_w[0];
            rd[19-k] = ready_w[0];
        end
        valid_v[0] = 1'b0;
        chk("b2b line", ln, 20'b01000000010000000011);
        chk("b2b done", dn, 20'b00000000010000000001);
        chk("b2b ready", rd, 20'b10000000001111111111);
        tick();
        chk("b2b idle out", out_w[0], 1);

        // Loopback stream into the receiver with in_valid held high
        rx_exp = '{8'h00, 8'hFF, 8'h5A};
        src = '{8'h00, 8'hFF, 8'h5A};
        rx_st = 0;
        rx_err = 0;
        rx_got.delete();
        rx_en = 1'b1;
        byte_v[0] = src.pop_front();
        valid_v[0] = 1'b1;
        for (int c = 0; c < 60 && rx_got.size() < 3; c++) begin
            acc0 = valid_v[0] && ready_w[0];
            tick();
            if (acc0) begin
                if (src.size() > 0) byte_v[0] = src.pop_front();
                else valid_v[0] = 1'b0;
            end
        end
        rx_en = 1'b0;
        valid_v[0] = 1'b0;
        chk("rx count", rx_got.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("rx byte%0d", i),
                (i < rx_got.size()) ? rx_got[i] : 8'hxx, rx_exp[i]);
        chk("rx errors", rx_err, 0);
        repeat (12) tick();

        // Randomized traffic on all three configurations
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                valid_v[i] = ((c % 300) < 240) && ($urandom_range(0, 3) != 0);
                byte_v[i] = 8'($urandom);
            end
            tick();
            if (c == 700) begin
                #2 reset = 1'b1;
                #1;
                mdl_reset();
                mdl_chk();
                #2 reset = 1'b0;
            end
        end
        valid_v = '0;
        repeat (50) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
